// File: rtl/voting_machine_advanced.sv
// -----------------------------------------------------------------------------
// voting_machine_advanced
//
// Password-gated five-candidate voting controller. A session is opened with
// start, unlocked with a 4-bit password, then takes one vote per button press
// for candidates A..E. end_voting closes the session and the winner's letter
// (or a dash on a tie) appears on a seven-segment display.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-high reset
//   start          in   open a session (IDLE/DONE only)
//   vote_A..vote_E in   candidate buttons (VOTING only)
//   end_voting     in   close the session (VOTING only)
//   auth           in   submit password_in (AUTH only)
//   password_in    in   [3:0] password value sampled with auth
//   winner_seg     out  [6:0] glyph {g,f,e,d,c,b,a}, active-high, blank unless DONE
//   vote_count_A..E out [3:0] per-candidate tallies, saturating at 15
//   auth_ok        out  session unlocked (level)
//   auth_fail      out  last attempt wrong, or machine locked (level)
//   state_dbg      out  [2:0] current FSM state, for observation only
//
// Handshake: all command inputs are level signals synchronous to clk. Each
// acts once per 0->1 transition relative to its previous-cycle value; a level
// held high is not repeated. There is no back-pressure. Results appear in the
// registered outputs one cycle after the edge that carried the command.
// -----------------------------------------------------------------------------
module voting_machine_advanced #(
  parameter logic [3:0] PASSWORD  = 4'b1010,
  parameter int         MAX_FAILS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       vote_A,
  input  logic       vote_B,
  input  logic       vote_C,
  input  logic       vote_D,
  input  logic       vote_E,
  input  logic       end_voting,
  input  logic       auth,
  input  logic [3:0] password_in,
  output logic [6:0] winner_seg,
  output logic [3:0] vote_count_A,
  output logic [3:0] vote_count_B,
  output logic [3:0] vote_count_C,
  output logic [3:0] vote_count_D,
  output logic [3:0] vote_count_E,
  output logic       auth_ok,
  output logic       auth_fail,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AUTH   = 3'd1,
    S_VOTING = 3'd2,
    S_DONE   = 3'd3,
    S_LOCKED = 3'd4
  } state_e;

  localparam int              FW        = (MAX_FAILS < 2) ? 1 : $clog2(MAX_FAILS + 1);
  localparam logic [FW-1:0]   LAST_FAIL = FW'(MAX_FAILS - 1);

  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b1111100;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q [5];
  logic [3:0]      cnt_d [5];
  logic [FW-1:0]   fail_cnt_q, fail_cnt_d;
  logic            auth_ok_q, auth_ok_d;
  logic            auth_fail_q, auth_fail_d;
  logic [6:0]      seg_q, seg_d;

  // Edge-detect history (previous-cycle input levels).
  logic            start_q, auth_q, end_q;
  logic [4:0]      vote_q;

  logic [4:0]      vote_in;
  logic [4:0]      vote_edge;
  logic            start_edge, auth_edge, end_edge;
  logic            single_vote;
  logic [2:0]      vote_idx;

  logic [3:0]      max_cnt;
  logic [2:0]      n_max;
  logic [2:0]      win_idx;
  logic [6:0]      glyph;

  assign vote_in    = {vote_E, vote_D, vote_C, vote_B, vote_A};
  assign vote_edge  = vote_in & ~vote_q;
  assign start_edge = start & ~start_q;
  assign auth_edge  = auth & ~auth_q;
  assign end_edge   = end_voting & ~end_q;

  // Exactly one vote edge: non-zero and a power of two. Simultaneous presses
  // are ambiguous and discarded.
  assign single_vote = (vote_edge != 5'd0) && ((vote_edge & (vote_edge - 5'd1)) == 5'd0);

  always_comb begin
    vote_idx = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (vote_edge[i]) vote_idx = 3'(i);
    end
  end

  // Winner from the current tallies: a unique maximum selects its letter,
  // any tie at the top (including all-zero) gives a dash.
  always_comb begin
    max_cnt = 4'd0;
    for (int i = 0; i < 5; i++) begin
      if (cnt_q[i] > max_cnt) max_cnt = cnt_q[i];
    end
    n_max   = 3'd0;
    win_idx = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (cnt_q[i] == max_cnt) begin
        n_max   = n_max + 3'd1;
        win_idx = 3'(i);
      end
    end
    if (n_max != 3'd1) begin
      glyph = SEG_DASH;
    end else begin
      case (win_idx)
        3'd0:    glyph = SEG_A;
        3'd1:    glyph = SEG_B;
        3'd2:    glyph = SEG_C;
        3'd3:    glyph = SEG_D;
        default: glyph = SEG_E;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fail_cnt_d  = fail_cnt_q;
    auth_ok_d   = auth_ok_q;
    auth_fail_d = auth_fail_q;
    seg_d       = SEG_BLANK;

    case (state_q)
      S_IDLE: begin
        if (start_edge) state_d = S_AUTH;
      end
      S_AUTH: begin
        if (auth_edge) begin
          if (password_in == PASSWORD) begin
            auth_ok_d   = 1'b1;
            auth_fail_d = 1'b0;
            fail_cnt_d  = '0;
            state_d     = S_VOTING;
          end else begin
            auth_fail_d = 1'b1;
            fail_cnt_d  = fail_cnt_q + FW'(1);
            if (fail_cnt_q == LAST_FAIL) state_d = S_LOCKED;
          end
        end
      end
      S_VOTING: begin
        // end_voting takes priority; coincident votes are dropped, so the
        // tallies seen by the winner logic are final.
        if (end_edge) begin
          state_d = S_DONE;
          seg_d   = glyph;
        end else if (single_vote && (cnt_q[vote_idx] != 4'd15)) begin
          cnt_d[vote_idx] = cnt_q[vote_idx] + 4'd1;
        end
      end
      S_DONE: begin
        seg_d = seg_q;
        if (start_edge) begin
          for (int i = 0; i < 5; i++) cnt_d[i] = 4'd0;
          auth_ok_d   = 1'b0;
          auth_fail_d = 1'b0;
          seg_d       = SEG_BLANK;
          state_d     = S_AUTH;
        end
      end
      S_LOCKED: begin
        auth_fail_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < 5; i++) cnt_q[i] <= 4'd0;
      fail_cnt_q  <= '0;
      auth_ok_q   <= 1'b0;
      auth_fail_q <= 1'b0;
      seg_q       <= SEG_BLANK;
      start_q     <= 1'b0;
      auth_q      <= 1'b0;
      end_q       <= 1'b0;
      vote_q      <= 5'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      auth_ok_q   <= auth_ok_d;
      auth_fail_q <= auth_fail_d;
      seg_q       <= seg_d;
      start_q     <= start;
      auth_q      <= auth;
      end_q       <= end_voting;
      vote_q      <= vote_in;
    end
  end

  assign winner_seg   = seg_q;
  assign vote_count_A = cnt_q[0];
  assign vote_count_B = cnt_q[1];
  assign vote_count_C = cnt_q[2];
  assign vote_count_D = cnt_q[3];
  assign vote_count_E = cnt_q[4];
  assign auth_ok      = auth_ok_q;
  assign auth_fail    = auth_fail_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_voting_machine_advanced.sv
// -----------------------------------------------------------------------------
// tb_voting_machine_advanced
//
// Self-checking bench for voting_machine_advanced: directed scenarios followed
// by randomized command traffic, all compared against a behavioural model of
// the voting rules kept in this file.
// -----------------------------------------------------------------------------
module tb_voting_machine_advanced;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0, end_voting = 1'b0, auth = 1'b0;
  logic [4:0] votes = 5'd0;
  logic [3:0] password_in = 4'd0;

  logic [6:0] winner_seg;
  logic [3:0] vote_count_A, vote_count_B, vote_count_C, vote_count_D, vote_count_E;
  logic       auth_ok, auth_fail;
  logic [2:0] state_dbg;

  voting_machine_advanced dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .vote_A       (votes[0]),
    .vote_B       (votes[1]),
    .vote_C       (votes[2]),
    .vote_D       (votes[3]),
    .vote_E       (votes[4]),
    .end_voting   (end_voting),
    .auth         (auth),
    .password_in  (password_in),
    .winner_seg   (winner_seg),
    .vote_count_A (vote_count_A),
    .vote_count_B (vote_count_B),
    .vote_count_C (vote_count_C),
    .vote_count_D (vote_count_D),
    .vote_count_E (vote_count_E),
    .auth_ok      (auth_ok),
    .auth_fail    (auth_fail),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_AUTH, M_VOTING, M_DONE, M_LOCKED} m_phase_e;
  m_phase_e m_phase;
  int       m_cnt [5];
  int       m_fails;
  bit       m_ok, m_fail;
  logic [6:0] m_winner;
  bit       p_start, p_auth, p_end;
  bit [4:0] p_votes;

  logic [6:0] glyphs [5];
  initial begin
    glyphs[0] = 7'b1110111;
    glyphs[1] = 7'b1111100;
    glyphs[2] = 7'b0111001;
    glyphs[3] = 7'b1011110;
    glyphs[4] = 7'b1111001;
  end

  function automatic logic [6:0] model_winner();
    int best = -1;
    int who = 0;
    int ties = 0;
    for (int i = 0; i < 5; i++) begin
      if (m_cnt[i] > best) begin
        best = m_cnt[i];
        who = i;
        ties = 1;
      end else if (m_cnt[i] == best) begin
        ties++;
      end
    end
    return (ties == 1) ? glyphs[who] : 7'b1000000;
  endfunction

  task automatic model_reset();
    m_phase = M_IDLE;
    for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    m_fails = 0;
    m_ok = 0;
    m_fail = 0;
    m_winner = 7'd0;
    p_start = 0; p_auth = 0; p_end = 0; p_votes = 0;
  endtask

  task automatic model_step(input bit s, input bit a, input bit e, input bit [4:0] v,
                            input bit [3:0] pw);
    bit s_e = s && !p_start;
    bit a_e = a && !p_auth;
    bit e_e = e && !p_end;
    int n_v = 0;
    int who = 0;
    for (int i = 0; i < 5; i++) begin
      if (v[i] && !p_votes[i]) begin
        n_v++;
        who = i;
      end
    end
    p_start = s; p_auth = a; p_end = e; p_votes = v;
    case (m_phase)
      M_IDLE: if (s_e) m_phase = M_AUTH;
      M_AUTH: if (a_e) begin
        if (pw == 4'b1010) begin
          m_ok = 1; m_fail = 0; m_fails = 0; m_phase = M_VOTING;
        end else begin
          m_fail = 1;
          m_fails++;
          if (m_fails >= 3) m_phase = M_LOCKED;
        end
      end
      M_VOTING: begin
        if (e_e) begin
          m_winner = model_winner();
          m_phase = M_DONE;
        end else if (n_v == 1 && m_cnt[who] < 15) begin
          m_cnt[who]++;
        end
      end
      M_DONE: if (s_e) begin
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
        m_ok = 0; m_fail = 0; m_phase = M_AUTH;
      end
      default: m_fail = 1;
    endcase
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".cnt_A"}, 32'(vote_count_A), 32'(m_cnt[0]));
    check({tag, ".cnt_B"}, 32'(vote_count_B), 32'(m_cnt[1]));
    check({tag, ".cnt_C"}, 32'(vote_count_C), 32'(m_cnt[2]));
    check({tag, ".cnt_D"}, 32'(vote_count_D), 32'(m_cnt[3]));
    check({tag, ".cnt_E"}, 32'(vote_count_E), 32'(m_cnt[4]));
    check({tag, ".auth_ok"}, 32'(auth_ok), 32'(m_ok));
    check({tag, ".auth_fail"}, 32'(auth_fail), 32'(m_fail));
    check({tag, ".seg"}, 32'(winner_seg), 32'((m_phase == M_DONE) ? m_winner : 7'd0));
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; applies inputs for one clock and checks after it.
  task automatic cycle(input string tag, input logic s, input logic a, input logic e,
                       input logic [4:0] v, input logic [3:0] pw);
    start = s; auth = a; end_voting = e; votes = v; password_in = pw;
    @(posedge clk);
    model_step(s, a, e, v, pw);
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0);
  endtask

  task automatic pulse_vote(input string tag, input logic [4:0] v);
    cycle(tag, 1'b0, 1'b0, 1'b0, v, 4'd0);
    idle(tag);
  endtask

  task automatic do_start(input string tag);
    cycle(tag, 1'b1, 1'b0, 1'b0, 5'd0, 4'd0);
    idle(tag);
  endtask

  task automatic do_auth(input string tag, input logic [3:0] pw);
    cycle(tag, 1'b0, 1'b1, 1'b0, 5'd0, pw);
    idle(tag);
  endtask

  task automatic do_end(input string tag);
    cycle(tag, 1'b0, 1'b0, 1'b1, 5'd0, 4'd0);
    idle(tag);
  endtask

  // Asserts reset between clock edges and checks it acts without a clock.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    start = 0; auth = 0; end_voting = 0; votes = 0; password_in = 0;
    #1;
    model_reset();
    compare_all(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    @(posedge clk);
    #1;
    compare_all("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Wrong then right password.
    do_start("start1");
    do_auth("bad_pw", 4'b0101);
    check("bad_pw.fail", 32'(auth_fail), 32'd1);
    check("bad_pw.ok", 32'(auth_ok), 32'd0);
    do_auth("good_pw", 4'b1010);
    check("good_pw.ok", 32'(auth_ok), 32'd1);
    check("good_pw.fail", 32'(auth_fail), 32'd0);

    // Votes A,B,C,D,A then end: A wins.
    pulse_vote("vA", 5'b00001);
    pulse_vote("vB", 5'b00010);
    pulse_vote("vC", 5'b00100);
    pulse_vote("vD", 5'b01000);
    pulse_vote("vA2", 5'b00001);
    do_end("end1");
    check("end1.A", 32'(vote_count_A), 32'd2);
    check("end1.E", 32'(vote_count_E), 32'd0);
    check("end1.seg", 32'(winner_seg), 32'h77);

    // Tie A,B -> dash; start clears.
    do_start("start2");
    check("start2.cnt_A", 32'(vote_count_A), 32'd0);
    do_auth("auth2", 4'b1010);
    pulse_vote("tA", 5'b00001);
    pulse_vote("tB", 5'b00010);
    do_end("end2");
    check("end2.dash", 32'(winner_seg), 32'h40);
    do_start("start3");
    check("start3.ok", 32'(auth_ok), 32'd0);
    check("start3.seg", 32'(winner_seg), 32'd0);

    // Vote before auth ignored, held level counts once, double press dropped.
    pulse_vote("pre_auth", 5'b00001);
    check("pre_auth.A", 32'(vote_count_A), 32'd0);
    do_auth("auth3", 4'b1010);
    for (int i = 0; i < 5; i++) cycle("holdC", 1'b0, 1'b0, 1'b0, 5'b00100, 4'd0);
    idle("holdC");
    check("holdC.C", 32'(vote_count_C), 32'd1);
    pulse_vote("AB", 5'b00011);
    check("AB.A", 32'(vote_count_A), 32'd0);
    // end_voting with a coincident vote: vote dropped, C stays sole leader.
    cycle("end_vote", 1'b0, 1'b0, 1'b1, 5'b00001, 4'd0);
    idle("end_vote");
    check("end_vote.A", 32'(vote_count_A), 32'd0);
    check("end_vote.seg", 32'(winner_seg), 32'h39);

    // Saturation on D.
    do_start("start4");
    do_auth("auth4", 4'b1010);
    for (int i = 0; i < 16; i++) pulse_vote("vD16", 5'b01000);
    check("sat.D", 32'(vote_count_D), 32'd15);
    do_end("end4");
    check("end4.seg", 32'(winner_seg), 32'h5e);

    // Lockout.
    do_start("start5");
    for (int i = 0; i < 3; i++) do_auth("wrong", 4'(i));
    do_auth("locked_pw", 4'b1010);
    check("locked.ok", 32'(auth_ok), 32'd0);
    check("locked.fail", 32'(auth_fail), 32'd1);
    do_start("locked_start");
    async_reset("rst_locked");

    // Reset mid-vote.
    do_start("start6");
    do_auth("auth6", 4'b1010);
    pulse_vote("mvE", 5'b10000);
    pulse_vote("mvE", 5'b10000);
    async_reset("rst_midvote");
    check("rst_midvote.E", 32'(vote_count_E), 32'd0);
    idle("post_rst");

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      logic s, a, e;
      logic [4:0] v;
      logic [3:0] pw;
      s = ($urandom_range(0, 7) == 0);
      a = ($urandom_range(0, 2) == 0);
      e = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < 5; k++) v[k] = ($urandom_range(0, 4) == 0);
      pw = ($urandom_range(0, 1) == 0) ? 4'b1010 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
      else cycle("rand", s, a, e, v, pw);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
